// File: rtl/signal_debouncer_pkg.sv
// ============================================================================
// Module   : signal_debouncer_pkg
// Purpose  : Shared definitions for the signal debouncer: qualify-FSM state
//            encodings, glitch counter width/limit and a small state helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package signal_debouncer_pkg;

  // Fixed 2-bit encodings; the LSB set means "qualifying a candidate".
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = {GLITCH_CNT_W{1'b1}};

  function automatic logic is_check(input state_t s);
    return (s == CHECK_HI) || (s == CHECK_LO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/signal_debouncer_sync_ff_chain.sv
// ============================================================================
// Module   : sync_ff_chain
// Purpose  : Generic multi-flop synchroniser for asynchronous inputs. Each bit
//            passes through STAGES flops; all flops reset to RESET_VALUE.
// Ports    : clk      - sampling clock
//            rst      - synchronous, active-high reset
//            i_async  - asynchronous input bus [WIDTH-1:0]
//            o_sync   - synchronised output (last flop) [WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff_chain #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [STAGES-1:0][WIDTH-1:0] stage_d;
  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = i_async;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {STAGES{RESET_VALUE}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_sync = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/signal_debouncer.sv
// ============================================================================
// Module   : signal_debouncer
// Purpose  : Turns a bouncing asynchronous level into a clean synchronous
//            level. A SYNC_STAGES-deep synchroniser feeds a 4-state qualify
//            FSM that accepts a new level only after STABLE_CYCLES equal
//            consecutive samples.
// Ports    : in_clock       - system clock (rising edge)
//            in_reset       - synchronous, active-high reset
//            in_signal      - raw asynchronous level
//            out_signal     - debounced level, straight from a flop
//            out_unstable   - 1 while a candidate transition is qualifying
//            out_glitch_cnt - saturating count of rejected transitions
// Config   : DEBOUNCE_GLITCH_CNT_EN - when defined, out_glitch_cnt is a live
//            saturating counter; otherwise it is tied to zero, no flops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_debouncer
  import signal_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_signal,
  output logic                    out_signal,
  output logic                    out_unstable,
  output logic [GLITCH_CNT_W-1:0] out_glitch_cnt
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic sync_s;

  sync_ff_chain #(
    .WIDTH       (1),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b0)
  ) u_sync (
    .clk     (in_clock),
    .rst     (in_reset),
    .i_async (in_signal),
    .o_sync  (sync_s)
  );

  state_t           state_d,    state_q;
  logic [CNT_W-1:0] cnt_d,      cnt_q;
  logic             signal_d,   signal_q;
  logic             unstable_d, unstable_q;

  // Next-state logic. Entering CHECK_* already counts the first equal
  // sample, so acceptance happens on the STABLE_CYCLES-th one. Any sample
  // back at the old level aborts and discards the partial count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signal_d = signal_q;
    case (state_q)
      STABLE_LO: begin
        if (sync_s) begin
          state_d = CHECK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_HI: begin
        if (!sync_s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_HI;
          signal_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_s) begin
          state_d = CHECK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_LO: begin
        if (sync_s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_LO;
          signal_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = STABLE_LO;
        cnt_d    = '0;
        signal_d = 1'b0;
      end
    endcase
    // Registered alongside the state so it never glitches.
    unstable_d = is_check(state_d);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= STABLE_LO;
      cnt_q      <= '0;
      signal_q   <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      signal_q   <= signal_d;
      unstable_q <= unstable_d;
    end
  end

  assign out_signal   = signal_q;
  assign out_unstable = unstable_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    abort;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_d, glitch_cnt_q;

  // An abort is a CHECK_* state seeing the old stable level again.
  always_comb begin
    abort        = ((state_q == CHECK_HI) && !sync_s) ||
                   ((state_q == CHECK_LO) &&  sync_s);
    glitch_cnt_d = glitch_cnt_q;
    if (abort && (glitch_cnt_q != GLITCH_CNT_MAX)) begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign out_glitch_cnt = glitch_cnt_q;
`else
  assign out_glitch_cnt = '0;
`endif

endmodule

`default_nettype wire
